// File: rtl/reversi_cmd_sequencer.sv
// Keyboard command sequencer for the reversi board: decodes PS/2 make codes,
// queues them, moves the cursor and hands placements to the game logic.
//
// state | meaning
// IDLE  | popping queued commands, one per cycle
// WAIT  | placement request outstanding, waiting for place_ack
module reversi_cmd_sequencer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] CURSOR_RST = 3'd3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid,
  input  logic       makeBreak,
  input  logic [7:0] outCode,
  input  logic       place_ack,
  input  logic       place_ok,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       place_req,
  output logic [2:0] place_x,
  output logic [2:0] place_y,
  output logic       player,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] CMD_RIGHT = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_UP    = 3'd2;
  localparam logic [2:0] CMD_DOWN  = 3'd3;
  localparam logic [2:0] CMD_PLACE = 3'd4;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state, stateNext;
  logic          accD, acc;
  logic          cmdValid;
  logic [2:0]    cmdCode;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          full, pushReq, doPush, doPop;
  logic [2:0]    headCmd;
  logic          startPlace, ackDone;
  logic [2:0]    cursorX, cursorY, placeX, placeY;
  logic          playerQ, overflowQ;

  // Rising edge of a held make code, so a long press yields one command.
  assign acc = valid & makeBreak & ~accD;

  always_comb begin
    cmdValid = 1'b1;
    cmdCode  = CMD_RIGHT;
    case (outCode)
      8'h74:   cmdCode = CMD_RIGHT;
      8'h6B:   cmdCode = CMD_LEFT;
      8'h75:   cmdCode = CMD_UP;
      8'h72:   cmdCode = CMD_DOWN;
      8'h5A:   cmdCode = CMD_PLACE;
      default: cmdValid = 1'b0;
    endcase
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pushReq = acc & cmdValid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign doPush  = pushReq & (~full | doPop);
  assign headCmd = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= cmdCode;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startPlace) stateNext = WAIT;
      WAIT:    if (place_ack)  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    doPop      = (state == IDLE) && (count != '0);
    startPlace = doPop && (headCmd == CMD_PLACE);
    ackDone    = (state == WAIT) && place_ack;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      accD      <= 1'b0;
      cursorX   <= CURSOR_RST;
      cursorY   <= CURSOR_RST;
      placeX    <= 3'd0;
      placeY    <= 3'd0;
      playerQ   <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      accD      <= valid & makeBreak;
      overflowQ <= pushReq & ~doPush;
      if (startPlace) begin
        placeX <= cursorX;
        placeY <= cursorY;
      end else if (doPop) begin
        case (headCmd)
          CMD_RIGHT: if (cursorX != 3'd7) cursorX <= cursorX + 3'd1;
          CMD_LEFT:  if (cursorX != 3'd0) cursorX <= cursorX - 3'd1;
          CMD_UP:    if (cursorY != 3'd0) cursorY <= cursorY - 3'd1;
          CMD_DOWN:  if (cursorY != 3'd7) cursorY <= cursorY + 3'd1;
          default:   ;
        endcase
      end
      if (ackDone && place_ok) playerQ <= ~playerQ;
    end
  end

  assign cursor_x  = cursorX;
  assign cursor_y  = cursorY;
  assign place_x   = placeX;
  assign place_y   = placeY;
  assign place_req = (state == WAIT);
  assign player    = playerQ;
  assign busy      = (count != '0) || (state == WAIT);
  assign overflow  = overflowQ;

endmodule

// File: doc/reversi_cmd_sequencer.md
# reversi_cmd_sequencer

Sits between the PS/2 scan-code driver and the reversi board/game logic. Decodes make codes into cursor-move and place commands, buffers them in a small FIFO, moves an on-board cursor within the 8x8 grid, and issues placement requests to the game logic with a req/ack handshake. While a placement is outstanding, it holds off further commands and tracks whose turn it is.

## Interface
Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16.
- CURSOR_RST, 3: reset value of both cursor_x and cursor_y, 0..7.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- valid  in  1  scan-code driver: outCode is valid this cycle (level, may stay high several cycles).
- makeBreak  in  1  1 = make (press), 0 = break (release).
- outCode  in  8  scan code.
- place_ack  in  1  game logic: placement request consumed (1-cycle pulse).
- place_ok  in  1  qualifies place_ack: 1 = legal move, turn passes.
- cursor_x  out  3  cursor column, 0..7.
- cursor_y  out  3  cursor row, 0..7.
- place_req  out  1  placement request, held until ack.
- place_x  out  3  column of the pending request, stable while place_req is high.
- place_y  out  3  row of the pending request, stable while place_req is high.
- player  out  1  side to move; 0 = black, 1 = white.
- busy  out  1  high when the FIFO is non-empty or the state is WAIT.
- overflow  out  1  1-cycle pulse: command dropped because the FIFO was full.

## Operation
- Accept strobe: acc = valid & makeBreak & ~acc_d, where acc_d is the registered value of (valid & makeBreak). One command per press, however long valid is held.
- Decode on acc:
  - 8'h74 -> RIGHT (x+1)
  - 8'h6B -> LEFT (x-1)
  - 8'h75 -> UP (y-1)
  - 8'h72 -> DOWN (y+1)
  - 8'h5A -> PLACE
  - any other code is ignored (no push, no overflow).
- FIFO:
  - 3-bit command code, synchronous push/pop, registered pointers plus count.
  - Push when full: command dropped, overflow pulses in the following cycle.
  - Push and pop in the same cycle while full: push accepted, no overflow.
  - No bypass: a push into an empty FIFO is not poppable in that cycle.
- FSM states IDLE and WAIT.
  - IDLE, FIFO non-empty: pop the head.
    - Move command: update the cursor and stay in IDLE. Saturate at 0 and 7, no wrap; a move at an edge is consumed with no change.
    - PLACE: latch place_x/place_y from the cursor, set place_req, go to WAIT.
  - WAIT: no pops; the FIFO keeps accepting pushes.
    - On place_ack: clear place_req. If place_ok, toggle player. Return to IDLE.
  - place_ack in IDLE is ignored. place_ok is ignored without place_ack.
- Cursor does not move during WAIT. Queued moves apply after ack.

## Timing
- Reset values (asynchronous, immediate on resetn low):
  - cursor_x = cursor_y = CURSOR_RST
  - place_x = place_y = 0
  - place_req = 0, player = 0, busy = 0, overflow = 0
  - FIFO empty, state IDLE, acc_d = 0
- Reset asserted during WAIT drops place_req at once. The pending request is lost.
- Latency for a key accepted in cycle N:
  - FIFO entry written at the end of N.
  - Popped in N+1 if the FIFO was empty and the state is IDLE.
  - cursor_x/cursor_y or place_req visible in N+2.
- Pop rate: one command per cycle in IDLE. A run of k queued moves completes k cycles after the first pop.
- Handshake:
  - place_req rises in N+2 and stays high with constant place_x/place_y until the cycle after place_ack.
  - place_ack seen in cycle M: place_req = 0 and the player toggle are visible in M+1.
  - The next pop happens no earlier than M+1.
- place_ack in the same cycle place_req first rises is valid.
- overflow is registered: high exactly one cycle, the cycle after the dropped push.

## Test plan
- Reset, then one RIGHT press (valid high 5 cycles, code 8'h74): cursor (3,3) -> (4,3) exactly 2 cycles after the valid edge; exactly one command consumed; busy low afterwards.
- Press UP 4 times from reset: cursor_y goes 3,2,1,0,0 (4th saturates); cursor_x stays 3.
- Press PLACE at (4,3):
  - place_req high with place_x=4, place_y=3.
  - Ack 6 cycles later with place_ok=1: place_req low and player=1 the next cycle.
  - Repeat with place_ok=0: player unchanged.
- Press PLACE, then 5 RIGHT presses before any ack (FIFO_DEPTH=4):
  - 4 moves queue; 5th press gives a 1-cycle overflow pulse.
  - cursor_x stays constant until ack, then rises 4 times on 4 consecutive cycles, saturating at 7.
- Press code 8'h1C, and separately send a break (makeBreak=0) of 8'h74: no FIFO push, cursor unchanged, busy stays 0.
- Assert resetn low while in WAIT with 2 moves queued: all outputs immediately return to reset values; after release, busy=0 and cursor=(3,3).
